instr_mem_loader: RTL and testbench

Write-side counterpart of the instruction memory: accepts a stream of instruction words over a valid/ready handshake and writes each one into the instruction-memory cell array as consecutive `MEM_CELL_SIZE`-bit cells, most-significant cell first. The cell order matches the fetch path, so cell `a` receives instruction bits `[WORD_LEN-1 -: MEM_CELL_SIZE]`. It sits between the program-load source (testbench or boot channel) and the instruction memory's cell write port, and replaces hard-coded memory initialisation.

---
 rtl/instr_mem_loader_pkg.sv | 14 +
 rtl/instr_mem_loader_if.sv | 26 ++
 rtl/instr_mem_loader_word_serializer.sv | 33 +++
 rtl/instr_mem_loader.sv | 75 +++++++
 tb/tb_instr_mem_loader.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared geometry constants and the loader state type.
//   WORD_LEN       instruction width in bits
//   MEM_CELL_SIZE  memory cell width in bits
//   INSTR_MEM_SIZE number of cells (power of two)
//   AW / CPW / KW  address width, cells per word, cell-index width
package instr_mem_loader_pkg;
    localparam int WORD_LEN       = 16;
    localparam int MEM_CELL_SIZE  = 4;
    localparam int INSTR_MEM_SIZE = 256;
    localparam int AW             = $clog2(INSTR_MEM_SIZE);
    localparam int CPW            = WORD_LEN / MEM_CELL_SIZE;
    localparam int KW             = $clog2(CPW);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: load-control, word handshake and cell write-port bundle.
//   master: program-load source (drives start/base_addr/num_words/in_valid/in_word)
//   slave:  loader (drives in_ready, mem_we/mem_addr/mem_wdata, busy/done/wrapped)
interface instr_mem_loader_if;
    import instr_mem_loader_pkg::*;
    logic                     start;
    logic [AW-1:0]            base_addr;
    logic [AW-1:0]            num_words;
    logic                     in_valid;
    logic [WORD_LEN-1:0]      in_word;
    logic                     in_ready;
    logic                     mem_we;
    logic [AW-1:0]            mem_addr;
    logic [MEM_CELL_SIZE-1:0] mem_wdata;
    logic                     busy;
    logic                     done;
    logic                     wrapped;
    modport master (
        output start, base_addr, num_words, in_valid, in_word,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped
    );
    modport slave (
        input  start, base_addr, num_words, in_valid, in_word,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped
    );
endinterface

// File: rtl/instr_mem_loader_word_serializer.sv
// word_serializer: parallel-load shift register emitting a word MSB cell first.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_load, i_word  load a new word (cell index restarts at 0); wins over i_shift
//   i_shift         advance to the next cell
//   o_cell          current cell (top MEM_CELL_SIZE bits)
//   o_last          current cell is the final one of the word
module word_serializer
    import instr_mem_loader_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic                     i_shift,
    input  logic [WORD_LEN-1:0]      i_word,
    output logic [MEM_CELL_SIZE-1:0] o_cell,
    output logic                     o_last
);
    logic [WORD_LEN-1:0] r_word;
    logic [KW-1:0]       r_k;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_word <= '0;
            r_k    <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_k    <= '0;
        end else if (i_shift) begin
            r_word <= r_word << MEM_CELL_SIZE;
            r_k    <= r_k + 1'b1;
        end
    assign o_cell = r_word[WORD_LEN-1 -: MEM_CELL_SIZE];
    assign o_last = r_k == KW'(CPW - 1);
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams instruction words into the cell array, MSB cell first.
//   i_clk, i_rst_n  clock, async active-low reset (aborts a load immediately)
//   io_bus          load control, word handshake, cell write port and status
module instr_mem_loader
    import instr_mem_loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    instr_mem_loader_if.slave   io_bus
);
    state_t                   r_state, w_next;
    logic [AW-1:0]            r_addr, r_rem;
    logic                     r_we, r_wrapped;
    logic                     w_in_ready, w_accept, w_last, w_final;
    logic [MEM_CELL_SIZE-1:0] w_cell;

    assign w_final    = r_rem == AW'(1);
    // On the last cell of a non-final word we already ask for the next one so
    // a waiting word follows with no bubble.
    assign w_in_ready = (r_state == LOAD) || (r_state == WRITE && w_last && !w_final);
    assign w_accept   = io_bus.in_valid && w_in_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = io_bus.start ? ((io_bus.num_words == '0) ? DONE : LOAD) : IDLE;
            LOAD:    w_next = w_accept ? WRITE : LOAD;
            WRITE:   w_next = !w_last ? WRITE : (w_final ? DONE : (w_accept ? WRITE : LOAD));
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_we      <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_next == WRITE;
            if (r_state == IDLE && io_bus.start) begin
                r_addr    <= io_bus.base_addr;
                r_rem     <= io_bus.num_words;
                r_wrapped <= 1'b0;
            end
            if (r_state == WRITE) begin
                r_addr <= r_addr + 1'b1;
                if (r_addr == '1)
                    r_wrapped <= 1'b1;
                if (w_last)
                    r_rem <= r_rem - 1'b1;
            end
        end

    word_serializer u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept),
        .i_shift (r_state == WRITE),
        .i_word  (io_bus.in_word),
        .o_cell  (w_cell),
        .o_last  (w_last)
    );

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.mem_we    = r_we;
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_wdata = w_cell;
    assign io_bus.busy      = r_state == LOAD || r_state == WRITE;
    assign io_bus.done      = r_state == DONE;
    assign io_bus.wrapped   = r_wrapped;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench with a cell-write scoreboard.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [AW+MEM_CELL_SIZE-1:0] exp_q[$];

    instr_mem_loader_if bus();
    instr_mem_loader dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to the next falling edge and score any cell write seen there.
    task automatic cyc();
        @(negedge clk);
        if (bus.mem_we) begin
            if (exp_q.size() == 0)
                chk("unexpected_we", 32'(bus.mem_we), 32'(0));
            else
                chk("cell", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [WORD_LEN-1:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({a, w[WORD_LEN-1-k*MEM_CELL_SIZE -: MEM_CELL_SIZE]});
            a = a + 1'b1;
        end
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] n);
        bus.start = 1'b1;
        bus.base_addr = b;
        bus.num_words = n;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [WORD_LEN-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_word = w;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_wrapped", 32'(bus.wrapped), 32'(0));
        cyc();
        rst_n = 1'b1;
        cyc();

        // single word
        go(8'd8, 8'd1);
        chk("t1_ready", 32'(bus.in_ready), 32'(1));
        chk("t1_busy", 32'(bus.busy), 32'(1));
        push(8'd8, 16'h301A, 4);
        feed(16'h301A);
        chk("t1_busy_wr", 32'(bus.busy), 32'(1));
        repeat (4) cyc();
        chk("t1_done", 32'(bus.done), 32'(1));
        chk("t1_busy_off", 32'(bus.busy), 32'(0));
        chk("t1_wrapped", 32'(bus.wrapped), 32'(0));
        chk("t1_drain", 32'(exp_q.size()), 32'(0));
        cyc();
        chk("t1_done_pulse", 32'(bus.done), 32'(0));

        // back-to-back words with in_valid held
        go(8'd12, 8'd2);
        push(8'd12, 16'h302B, 4);
        bus.in_valid = 1'b1;
        bus.in_word = 16'h302B;
        cyc();
        push(8'd16, 16'h3033, 4);
        bus.in_word = 16'h3033;
        repeat (3) cyc();
        chk("t2_ready_k3", 32'(bus.in_ready), 32'(1));
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("t2_ready_last", 32'(bus.in_ready), 32'(0));
        cyc();
        chk("t2_done", 32'(bus.done), 32'(1));
        chk("t2_drain", 32'(exp_q.size()), 32'(0));
        cyc();

        // stalled source between words
        go(8'd40, 8'd2);
        push(8'd40, 16'h1234, 4);
        feed(16'h1234);
        repeat (3) cyc();
        chk("t3_ready_k3", 32'(bus.in_ready), 32'(1));
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("t3_gap_ready", 32'(bus.in_ready), 32'(1));
            chk("t3_gap_we", 32'(bus.mem_we), 32'(0));
            cyc();
        end
        push(8'd44, 16'hABCD, 4);
        feed(16'hABCD);
        repeat (4) cyc();
        chk("t3_done", 32'(bus.done), 32'(1));
        chk("t3_drain", 32'(exp_q.size()), 32'(0));
        cyc();

        // zero length
        go(8'd5, 8'd0);
        chk("t4_done", 32'(bus.done), 32'(1));
        chk("t4_ready", 32'(bus.in_ready), 32'(0));
        chk("t4_busy", 32'(bus.busy), 32'(0));
        cyc();
        chk("t4_done_pulse", 32'(bus.done), 32'(0));
        chk("t4_ready_after", 32'(bus.in_ready), 32'(0));

        // address wrap
        go(8'd254, 8'd1);
        push(8'd254, 16'hC311, 4);
        feed(16'hC311);
        chk("t5_wrap_254", 32'(bus.wrapped), 32'(0));
        cyc();
        chk("t5_wrap_255", 32'(bus.wrapped), 32'(0));
        cyc();
        chk("t5_wrap_set", 32'(bus.wrapped), 32'(1));
        repeat (2) cyc();
        chk("t5_done", 32'(bus.done), 32'(1));
        chk("t5_drain", 32'(exp_q.size()), 32'(0));
        cyc();
        chk("t5_wrap_sticky", 32'(bus.wrapped), 32'(1));

        // reset during the third cell
        go(8'd100, 8'd1);
        chk("t6_wrap_clr", 32'(bus.wrapped), 32'(0));
        push(8'd100, 16'h5A5A, 3);
        feed(16'h5A5A);
        repeat (2) cyc();
        chk("t6_drain", 32'(exp_q.size()), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_we", 32'(bus.mem_we), 32'(0));
        chk("t6_async_busy", 32'(bus.busy), 32'(0));
        chk("t6_async_ready", 32'(bus.in_ready), 32'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_idle_busy", 32'(bus.busy), 32'(0));
        chk("t6_idle_ready", 32'(bus.in_ready), 32'(0));
        go(8'd200, 8'd1);
        push(8'd200, 16'h9876, 4);
        feed(16'h9876);
        repeat (4) cyc();
        chk("t6_done", 32'(bus.done), 32'(1));
        chk("t6_reload_drain", 32'(exp_q.size()), 32'(0));
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
